// File: rtl/async_elastic_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : async_elastic_buffer_pkg
// Brief    : Shared async-fabric definitions: fan-out mode encodings and a
//            modulo pointer-increment helper.
// Revision : 1.0
// ============================================================================
package async_elastic_buffer_pkg;

    localparam int FANOUT_INDEPENDENT = 0;
    localparam int FANOUT_LOCKSTEP    = 1;

    // Wraps at an arbitrary depth, so DEPTH need not be a power of two
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/async_elastic_buffer_fanout_tracker.sv
`default_nettype none
// ============================================================================
// Module   : fanout_tracker
// Brief    : Issues per-consumer ack_r grants for the head word and raises
//            pop once every consumer has taken it.
// Revision : 1.0
// ============================================================================
module fanout_tracker
    import async_elastic_buffer_pkg::*;
#(
    parameter int OUTPUT_SIZE = 1,
    parameter int FANOUT_MODE = FANOUT_INDEPENDENT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   head_valid,
    input  logic [OUTPUT_SIZE-1:0] req_r,
    output logic [OUTPUT_SIZE-1:0] ack_r,
    output logic                   pop
);

    generate
        if (FANOUT_MODE == FANOUT_LOCKSTEP) begin : g_lockstep
            logic w_fire;

            assign w_fire = head_valid & (&req_r) & (ack_r == '0);
            assign pop    = w_fire;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ack_r <= '0;
                end else begin
                    ack_r <= {OUTPUT_SIZE{w_fire}};
                end
            end
        end else begin : g_independent
            localparam logic [OUTPUT_SIZE-1:0] c_ALL = '1;

            logic [OUTPUT_SIZE-1:0] r_served;
            logic [OUTPUT_SIZE-1:0] w_grant;

            // The ~ack_r term enforces a one-cycle gap between a consumer's acks
            assign w_grant = {OUTPUT_SIZE{head_valid}} & req_r & ~r_served & ~ack_r;
            assign pop     = head_valid & ((r_served | w_grant) == c_ALL);

            always_ff @(posedge clk) begin
                if (rst) begin
                    ack_r    <= '0;
                    r_served <= '0;
                end else begin
                    ack_r    <= w_grant;
                    r_served <= pop ? '0 : (r_served | w_grant);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/async_elastic_buffer.sv
`default_nettype none
// ============================================================================
// Module   : async_elastic_buffer
// Brief    : DEPTH-entry req/ack elastic buffer fanning its head word out to
//            OUTPUT_SIZE consumers in independent or lockstep mode.
// Revision : 1.0
// ============================================================================
module async_elastic_buffer
    import async_elastic_buffer_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  DEPTH       = 4,
    parameter int  OUTPUT_SIZE = 1,
    parameter int  FANOUT_MODE = FANOUT_INDEPENDENT,
    localparam int OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   req_l,
    input  logic                   ack_l,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic [OUTPUT_SIZE-1:0] req_r,
    output logic [OUTPUT_SIZE-1:0] ack_r,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic [OCC_W-1:0]       occupancy,
    output logic                   overflow
);

    localparam int               c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OCC_W-1:0] c_FULL  = OCC_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  w_head_valid;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [OCC_W-1:0]      w_occ_next;

    assign w_head_valid = (occupancy != '0);
    assign w_full       = (occupancy == c_FULL);
    // A word arriving while full is dropped even if the head pops this edge
    assign w_push       = ack_l & ~w_full;

    always_comb begin
        w_occ_next = occupancy;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = occupancy + OCC_W'(1);
            2'b01:   w_occ_next = occupancy - OCC_W'(1);
            default: w_occ_next = occupancy;
        endcase
    end

    fanout_tracker #(
        .OUTPUT_SIZE (OUTPUT_SIZE),
        .FANOUT_MODE (FANOUT_MODE)
    ) u_fanout_tracker (
        .clk        (clk),
        .rst        (rst),
        .head_valid (w_head_valid),
        .req_r      (req_r),
        .ack_r      (ack_r),
        .pop        (w_pop)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            occupancy <= '0;
            req_l     <= 1'b0;
            overflow  <= 1'b0;
            dout      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= c_PTR_W'(wrap_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= c_PTR_W'(wrap_inc(32'(r_rd_ptr), DEPTH));
            end
            occupancy <= w_occ_next;
            // Dropping req_l on every ack keeps at most one transfer in flight
            req_l     <= ~ack_l & (w_occ_next < c_FULL);
            if (ack_l & w_full) begin
                overflow <= 1'b1;
            end
            if (w_head_valid) begin
                dout <= r_mem[r_rd_ptr];
            end
        end
    end

endmodule
`default_nettype wire
